// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl
// Brief    : MODE/INC time-set controller for the BCD 12-hour clock: field
//            editing, hold, commit strobe, blink phases and idle timeout.
//            Optional macro AUTO_REPEAT_EN adds held-INC auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int TIMEOUT_SEC = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_hour_tens,
    input  logic [3:0] cur_hour_units,
    input  logic [3:0] cur_min_tens,
    input  logic [3:0] cur_min_units,
    input  logic       cur_is_am,
    output logic       editing,
    output logic       hold,
    output logic       load,
    output logic [7:0] edit_hour,
    output logic [7:0] edit_min,
    output logic       edit_is_am,
    output logic       blink_hour,
    output logic       blink_min,
    output logic       blink_ampm
);

    localparam int c_CYC_W = $clog2(CLK_FREQ);
    localparam int c_SEC_W = $clog2(TIMEOUT_SEC + 1);
    localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(CLK_FREQ - 1);
    localparam logic [c_CYC_W-1:0] c_CYC_HALF = c_CYC_W'(CLK_FREQ / 2 - 1);
    localparam logic [c_CYC_W-1:0] c_CYC_ONE  = c_CYC_W'(1);
    localparam logic [c_SEC_W-1:0] c_SEC_LAST = c_SEC_W'(TIMEOUT_SEC - 1);
    localparam logic [c_SEC_W-1:0] c_SEC_ONE  = c_SEC_W'(1);

    localparam logic [2:0] c_ST_RUN    = 3'd0;
    localparam logic [2:0] c_ST_HOUR   = 3'd1;
    localparam logic [2:0] c_ST_MIN    = 3'd2;
    localparam logic [2:0] c_ST_AMPM   = 3'd3;
    localparam logic [2:0] c_ST_COMMIT = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_mode_prev;
    logic               r_inc_prev;
    logic               r_mode_edge;
    logic               r_inc_edge;
    logic [7:0]         r_edit_hour;
    logic [7:0]         r_edit_min;
    logic               r_edit_is_am;
    logic [c_CYC_W-1:0] r_cyc_cnt;
    logic [c_SEC_W-1:0] r_sec_cnt;
    logic               r_phase;
    logic               w_is_edit;
    logic               w_inc_any;
    logic               w_inc_act;
    logic               w_timeout;

    function automatic logic [7:0] f_hour_inc(input logic [7:0] h);
        if (h == 8'h12)
            return 8'h01;
        else if (h[3:0] == 4'd9)
            return {h[7:4] + 4'd1, 4'd0};
        else
            return {h[7:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] f_min_inc(input logic [7:0] m);
        if (m == 8'h59)
            return 8'h00;
        else if (m[3:0] == 4'd9)
            return {m[7:4] + 4'd1, 4'd0};
        else
            return {m[7:4], m[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_prev <= 1'b0;
            r_inc_prev  <= 1'b0;
            r_mode_edge <= 1'b0;
            r_inc_edge  <= 1'b0;
        end else begin
            r_mode_prev <= btn_mode;
            r_inc_prev  <= btn_inc;
            r_mode_edge <= btn_mode & ~r_mode_prev;
            r_inc_edge  <= btn_inc & ~r_inc_prev;
        end
    end

    assign w_is_edit = (r_state == c_ST_HOUR) || (r_state == c_ST_MIN) || (r_state == c_ST_AMPM);
    assign w_timeout = w_is_edit && (r_cyc_cnt == c_CYC_LAST) && (r_sec_cnt == c_SEC_LAST);

`ifdef AUTO_REPEAT_EN
    // First repeat after half a second of continuous hold, then every 1/8 s.
    localparam logic [c_CYC_W-1:0] c_REP_FIRST = c_CYC_W'(CLK_FREQ / 2 - 1);
    localparam logic [c_CYC_W-1:0] c_REP_NEXT  = c_CYC_W'(CLK_FREQ / 8 - 1);

    logic [c_CYC_W-1:0] r_rep_cnt;
    logic               r_rep_armed;
    logic               w_rep_held;
    logic               w_rep_fire;

    assign w_rep_held = w_is_edit && btn_inc && r_inc_prev;
    assign w_rep_fire = w_rep_held && (r_rep_cnt == (r_rep_armed ? c_REP_NEXT : c_REP_FIRST));
    assign w_inc_any  = r_inc_edge | w_rep_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (!w_rep_held) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b1;
        end else begin
            r_rep_cnt   <= r_rep_cnt + c_CYC_ONE;
        end
    end
`else
    assign w_inc_any = r_inc_edge;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= c_ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    // MODE beats INC, and any accepted INC beats the timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_inc_act   = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (r_mode_edge)
                    w_state_nxt = c_ST_HOUR;
            end
            c_ST_HOUR, c_ST_MIN, c_ST_AMPM: begin
                if (r_mode_edge)
                    w_state_nxt = r_state + 3'd1;
                else if (w_inc_any)
                    w_inc_act = 1'b1;
                else if (w_timeout)
                    w_state_nxt = c_ST_RUN;
            end
            default: w_state_nxt = c_ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edit_hour  <= 8'h12;
            r_edit_min   <= 8'h00;
            r_edit_is_am <= 1'b1;
            r_cyc_cnt    <= '0;
            r_sec_cnt    <= '0;
            r_phase      <= 1'b0;
        end else begin
            if ((r_state == c_ST_RUN) && r_mode_edge) begin
                r_edit_hour  <= {cur_hour_tens, cur_hour_units};
                r_edit_min   <= {cur_min_tens, cur_min_units};
                r_edit_is_am <= cur_is_am;
            end else if (w_inc_act) begin
                case (r_state)
                    c_ST_HOUR: r_edit_hour  <= f_hour_inc(r_edit_hour);
                    c_ST_MIN:  r_edit_min   <= f_min_inc(r_edit_min);
                    c_ST_AMPM: r_edit_is_am <= ~r_edit_is_am;
                    default:   ;
                endcase
            end

            // One cycle counter serves both the blink half-periods and the seconds.
            if (w_state_nxt != r_state) begin
                r_cyc_cnt <= '0;
                r_sec_cnt <= '0;
                r_phase   <= 1'b0;
            end else if (w_inc_act) begin
                r_cyc_cnt <= '0;
                r_sec_cnt <= '0;
                r_phase   <= 1'b1;
            end else if (w_is_edit) begin
                if (r_cyc_cnt == c_CYC_LAST) begin
                    r_cyc_cnt <= '0;
                    r_sec_cnt <= r_sec_cnt + c_SEC_ONE;
                    r_phase   <= ~r_phase;
                end else begin
                    r_cyc_cnt <= r_cyc_cnt + c_CYC_ONE;
                    if (r_cyc_cnt == c_CYC_HALF)
                        r_phase <= ~r_phase;
                end
            end
        end
    end

    assign editing    = w_is_edit;
    assign hold       = w_is_edit;
    assign load       = (r_state == c_ST_COMMIT);
    assign edit_hour  = r_edit_hour;
    assign edit_min   = r_edit_min;
    assign edit_is_am = r_edit_is_am;
    assign blink_hour = (r_state == c_ST_HOUR) & r_phase;
    assign blink_min  = (r_state == c_ST_MIN) & r_phase;
    assign blink_ampm = (r_state == c_ST_AMPM) & r_phase;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_set_ctrl
// Brief    : Self-checking bench for clock_set_ctrl: directed edit sequences
//            plus randomized buttons against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

    localparam int CLK_FREQ    = 100;
    localparam int TIMEOUT_SEC = 10;
    localparam int HALF        = CLK_FREQ / 2;
    localparam int TIMEOUT_CYC = CLK_FREQ * TIMEOUT_SEC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] cur_hour_tens = 4'd0;
    logic [3:0] cur_hour_units = 4'd9;
    logic [3:0] cur_min_tens = 4'd4;
    logic [3:0] cur_min_units = 4'd1;
    logic       cur_is_am = 1'b1;
    logic       editing, hold, load;
    logic [7:0] edit_hour, edit_min;
    logic       edit_is_am, blink_hour, blink_min, blink_ampm;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_load  = 0;
    bit chk_en  = 1'b0;

    clock_set_ctrl #(
        .CLK_FREQ   (CLK_FREQ),
        .TIMEOUT_SEC(TIMEOUT_SEC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_mode      (btn_mode),
        .btn_inc       (btn_inc),
        .cur_hour_tens (cur_hour_tens),
        .cur_hour_units(cur_hour_units),
        .cur_min_tens  (cur_min_tens),
        .cur_min_units (cur_min_units),
        .cur_is_am     (cur_is_am),
        .editing       (editing),
        .hold          (hold),
        .load          (load),
        .edit_hour     (edit_hour),
        .edit_min      (edit_min),
        .edit_is_am    (edit_is_am),
        .blink_hour    (blink_hour),
        .blink_min     (blink_min),
        .blink_ampm    (blink_ampm)
    );

    always #5 clk = ~clk;

    // Model: field 0=idle, 1=hour, 2=minute, 3=AM/PM, 4=commit cycle.
    // Times and values are plain integers; m_since counts cycles since the
    // last field entry or accepted INC, and m_vis is the blink phase then.
    int   m_field, m_hour, m_min, m_since;
    logic m_am, m_vis, m_prev_mode, m_prev_inc, m_mode_ev, m_inc_ev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_field <= 0;  m_hour <= 12;  m_min <= 0;  m_am <= 1'b1;
            m_since <= 0;  m_vis <= 1'b0;
            m_prev_mode <= 1'b0;  m_prev_inc <= 1'b0;
            m_mode_ev <= 1'b0;    m_inc_ev <= 1'b0;
        end else begin
            m_prev_mode <= btn_mode;
            m_prev_inc  <= btn_inc;
            m_mode_ev   <= btn_mode && !m_prev_mode;
            m_inc_ev    <= btn_inc && !m_prev_inc;
            if (m_field == 0) begin
                if (m_mode_ev) begin
                    m_field <= 1;
                    m_hour  <= cur_hour_tens * 10 + cur_hour_units;
                    m_min   <= cur_min_tens * 10 + cur_min_units;
                    m_am    <= cur_is_am;
                    m_since <= 0;
                    m_vis   <= 1'b0;
                end
            end else if (m_field == 4) begin
                m_field <= 0;
            end else if (m_mode_ev) begin
                m_field <= m_field + 1;
                m_since <= 0;
                m_vis   <= 1'b0;
            end else if (m_inc_ev) begin
                if (m_field == 1)      m_hour <= (m_hour == 12) ? 1 : m_hour + 1;
                else if (m_field == 2) m_min  <= (m_min + 1) % 60;
                else                   m_am   <= !m_am;
                m_since <= 0;
                m_vis   <= 1'b1;
            end else if (m_since == TIMEOUT_CYC - 1) begin
                m_field <= 0;
                m_since <= 0;
            end else begin
                m_since <= m_since + 1;
            end
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic       ed, ph;
        forever begin
            @(posedge clk);
            #1;
            if (load) n_load++;
            if (chk_en) begin
                ed = (m_field >= 1) && (m_field <= 3);
                ph = m_vis ^ (((m_since / HALF) % 2) == 1);
                check("m_editing", {7'd0, editing}, {7'd0, ed});
                check("m_hold", {7'd0, hold}, {7'd0, ed});
                check("m_load", {7'd0, load}, {7'd0, m_field == 4});
                check("m_edit_hour", edit_hour, to_bcd(m_hour));
                check("m_edit_min", edit_min, to_bcd(m_min));
                check("m_edit_is_am", {7'd0, edit_is_am}, {7'd0, m_am});
                check("m_blink_hour", {7'd0, blink_hour}, {7'd0, (m_field == 1) && ph});
                check("m_blink_min", {7'd0, blink_min}, {7'd0, (m_field == 2) && ph});
                check("m_blink_ampm", {7'd0, blink_ampm}, {7'd0, (m_field == 3) && ph});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic i);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cyc(2);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        logic [7:0] hour_seq [4];
        logic [7:0] min_seq [3];
        int         ld0;
        int         h, mn;
        hour_seq = '{8'h10, 8'h11, 8'h12, 8'h01};
        min_seq  = '{8'h59, 8'h00, 8'h01};

        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        cyc(2);
        check("rst_editing", {7'd0, editing}, 8'd0);
        check("rst_load", {7'd0, load}, 8'd0);
        check("rst_edit_hour", edit_hour, 8'h12);
        check("rst_edit_min", edit_min, 8'h00);
        check("rst_edit_is_am", {7'd0, edit_is_am}, 8'd1);
        rst_n = 1'b1;
        cyc(2);

        // Capture of 09:41 AM on entry
        press(1'b1, 1'b0);
        check("enter_editing", {7'd0, editing}, 8'd1);
        check("enter_hold", {7'd0, hold}, 8'd1);
        check("enter_hour", edit_hour, 8'h09);
        check("enter_min", edit_min, 8'h41);
        foreach (hour_seq[k]) begin
            press(1'b0, 1'b1);
            check("hour_inc", edit_hour, hour_seq[k]);
        end
        press(1'b1, 1'b0);
        repeat (17) press(1'b0, 1'b1);
        check("min_to_58", edit_min, 8'h58);
        foreach (min_seq[k]) begin
            press(1'b0, 1'b1);
            check("min_inc", edit_min, min_seq[k]);
        end
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("ampm_toggle", {7'd0, edit_is_am}, 8'd0);
        ld0 = n_load;
        press(1'b1, 1'b0);
        cyc(2);
        check("commit_pulses", 8'(n_load - ld0), 8'd1);
        check("commit_hour", edit_hour, 8'h01);
        check("commit_min", edit_min, 8'h01);
        check("commit_is_am", {7'd0, edit_is_am}, 8'd0);
        check("commit_hold", {7'd0, hold}, 8'd0);

        // Idle timeout in SET_MIN
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        ld0 = n_load;
        cyc(TIMEOUT_CYC - 20);
        check("pre_timeout_editing", {7'd0, editing}, 8'd1);
        cyc(40);
        check("timeout_editing", {7'd0, editing}, 8'd0);
        check("timeout_no_load", 8'(n_load - ld0), 8'd0);
        check("timeout_keeps_hour", edit_hour, 8'h09);

        // MODE and INC together: MODE wins
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        check("mode_inc_hour", edit_hour, 8'h09);
        press(1'b0, 1'b1);
        check("in_set_min", edit_min, 8'h42);
        check("in_set_min_hour", edit_hour, 8'h09);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_editing", {7'd0, editing}, 8'd0);
        check("async_rst_hold", {7'd0, hold}, 8'd0);
        check("async_rst_load", {7'd0, load}, 8'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Randomized buttons and live time
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                h  = int'($urandom_range(1, 12));
                mn = int'($urandom_range(0, 59));
                cur_hour_tens  = 4'(h / 10);
                cur_hour_units = 4'(h % 10);
                cur_min_tens   = 4'(mn / 10);
                cur_min_units  = 4'(mn % 10);
                cur_is_am      = 1'($urandom_range(0, 1));
            end
            btn_mode = ($urandom_range(0, 15) == 0);
            btn_inc  = ($urandom_range(0, 3) == 0);
            if (k == 1500) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
        end
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        reset_pulse();

        // Long INC hold in SET_MIN starting from 00
        cur_hour_tens  = 4'd0;
        cur_hour_units = 4'd3;
        cur_min_tens   = 4'd0;
        cur_min_units  = 4'd0;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("hold_start_min", edit_min, 8'h00);
`ifdef AUTO_REPEAT_EN
        chk_en = 1'b0;
`endif
        @(negedge clk);
        btn_inc = 1'b1;
        cyc(74);
        btn_inc = 1'b0;
        cyc(3);
`ifdef AUTO_REPEAT_EN
        check("repeat_advanced", {7'd0, edit_min > 8'h01}, 8'd1);
`else
        check("single_action_min", edit_min, 8'h01);
`endif
        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
